univ_shift_frame: RTL

UNIV_SHIFT_FRAME -- requirements
Module: univ_shift_frame

---
 rtl/univ_shift_frame.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/univ_shift_frame.sv
// -----------------------------------------------------------------------------
// univ_shift_frame
// Universal N-bit shift register with two ways of using it:
//   * manual mode (IDLE): ctrl_i selects hold / shift left / shift right /
//     parallel load on every clock edge;
//   * framed mode: start_i launches an N-bit shift in a latched direction.
//     One shift happens on each edge with tick_i=1, and done_o pulses for one
//     cycle after the last shift of the frame.
//
// Ports
//   clk_i    : sole clock, all state changes on its rising edge
//   rst_ni   : asynchronous active-low reset
//   ctrl_i   : manual mode in IDLE (00 hold, 01 left, 10 right, 11 load)
//   d_i      : parallel load data
//   s_in_i   : serial input bit
//   start_i  : request a framed shift (sampled in IDLE only)
//   dir_i    : frame direction sampled with start_i (0 right, 1 left)
//   tick_i   : shift enable while a frame runs
//   q_o      : register contents
//   s_out_o  : serial output, q[0] for right, q[N-1] for left
//   busy_o   : frame in progress
//   done_o   : one-cycle frame completion pulse
// -----------------------------------------------------------------------------
module univ_shift_frame #(
    parameter int N = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [1:0]   ctrl_i,
    input  logic [N-1:0] d_i,
    input  logic         s_in_i,
    input  logic         start_i,
    input  logic         dir_i,
    input  logic         tick_i,
    output logic [N-1:0] q_o,
    output logic         s_out_o,
    output logic         busy_o,
    output logic         done_o
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    q_q, q_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    // Active direction: 1 = left, 0 = right. Drives s_out_o selection.
    logic            dir_q, dir_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [N-1:0]    shl_s;
    logic [N-1:0]    shr_s;

    assign shl_s = {q_q[N-2:0], s_in_i};
    assign shr_s = {s_in_i, q_q[N-1:1]};

    // Next-state, data path and flag computation for both states.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    // start wins over ctrl; q is left untouched on this edge
                    dir_d   = dir_i;
                    cnt_d   = {CW{1'b0}};
                    state_d = ST_SHIFT;
                end else begin
                    case (ctrl_i)
                        2'b01: begin
                            q_d   = shl_s;
                            dir_d = 1'b1;
                        end
                        2'b10: begin
                            q_d   = shr_s;
                            dir_d = 1'b0;
                        end
                        2'b11: begin
                            q_d = d_i;
                        end
                        default: begin
                            q_d = q_q;
                        end
                    endcase
                end
            end
            ST_SHIFT: begin
                if (tick_i) begin
                    q_d = dir_q ? shl_s : shr_s;
                    if (cnt_q == CW'(N - 1)) begin
                        cnt_d   = {CW{1'b0}};
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    q_d = q_q;
                end
            end
            default: begin
                // unreachable encoding: fall back to a safe idle
                state_d = ST_IDLE;
                cnt_d   = {CW{1'b0}};
            end
        endcase

        busy_d = (state_d == ST_SHIFT);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            q_q     <= {N{1'b0}};
            cnt_q   <= {CW{1'b0}};
            dir_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign q_o     = q_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign s_out_o = dir_q ? q_q[N-1] : q_q[0];

endmodule
